// File: rtl/coherence_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// coherence_bus_ctrl_if
// Bundles the per-core cache handshakes, snoop signals and RAM port of the
// coherence bus controller. Per-core signals are flattened vectors indexed
// by core number (core k occupies bits [k*WORD_W +: WORD_W] of wide buses).
//
// Modports:
//   slave  - the bus controller (takes requests, drives waits/snoops/RAM)
//   master - the caches plus RAM model (drive requests, snoop replies, RAM)
// ---------------------------------------------------------------------------
interface coherence_bus_ctrl_if #(
  parameter int NUM_CORES = 2,
  parameter int WORD_W    = 32
);
  // Instruction fetch side
  logic [NUM_CORES-1:0]        iREN;
  logic [NUM_CORES*WORD_W-1:0] iaddr;
  logic [NUM_CORES-1:0]        iwait;
  logic [WORD_W-1:0]           iload;
  // Data side
  logic [NUM_CORES-1:0]        dREN;
  logic [NUM_CORES-1:0]        dWEN;
  logic [NUM_CORES*WORD_W-1:0] daddr;
  logic [NUM_CORES*WORD_W-1:0] dstore;
  logic [NUM_CORES-1:0]        dwait;
  logic [WORD_W-1:0]           dload;
  // Coherence (snoop) side
  logic [NUM_CORES-1:0]        ccwrite;
  logic [NUM_CORES-1:0]        cctrans;
  logic [NUM_CORES-1:0]        ccdirty;
  logic [NUM_CORES-1:0]        ccwait;
  logic [NUM_CORES-1:0]        ccinv;
  logic [WORD_W-1:0]           ccsnoopaddr;
  // Single-ported RAM
  logic                        ramREN;
  logic                        ramWEN;
  logic [WORD_W-1:0]           ramaddr;
  logic [WORD_W-1:0]           ramstore;
  logic [WORD_W-1:0]           ramload;
  logic                        ram_ready;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans, ccdirty,
           ramload, ram_ready,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans, ccdirty,
           ramload, ram_ready,
    input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// ---------------------------------------------------------------------------
// coherence_bus_ctrl
// MSI snooping bus controller for NUM_CORES cores sharing one single-ported
// RAM. Arbitrates instruction fetches, dirty-block writebacks and coherent
// read misses (round-robin, data before instruction), moves two-word blocks,
// and forwards dirty blocks cache-to-cache while updating RAM in parallel.
//
// Ports:
//   CLK   - clock, rising edge
//   nRST  - asynchronous active-low reset
//   bus   - coherence_bus_ctrl_if.slave (cache, snoop and RAM signals)
//   snoop_cnt, c2c_cnt, inv_cnt - 32-bit event counters, present only when
//                                 COHERENCE_PERF_EN is defined
//
// Optional build macro: COHERENCE_PERF_EN (performance counters).
// ---------------------------------------------------------------------------
module coherence_bus_ctrl #(
  parameter int NUM_CORES = 2,
  parameter int WORD_W    = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  coherence_bus_ctrl_if.slave    bus
`ifdef COHERENCE_PERF_EN
  ,
  output logic [31:0]            snoop_cnt,
  output logic [31:0]            c2c_cnt,
  output logic [31:0]            inv_cnt
`endif
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] IFETCH = 4'd1;
  localparam logic [3:0] WB1    = 4'd2;
  localparam logic [3:0] WB2    = 4'd3;
  localparam logic [3:0] SNOOP  = 4'd4;
  localparam logic [3:0] C2C1   = 4'd5;
  localparam logic [3:0] C2C2   = 4'd6;
  localparam logic [3:0] MLD1   = 4'd7;
  localparam logic [3:0] MLD2   = 4'd8;

  logic [3:0]           state_r, state_nxt_s;
  logic [IDX_W-1:0]     owner_r, owner_nxt_s;
  logic [IDX_W-1:0]     supplier_r, supplier_nxt_s;
  logic [IDX_W-1:0]     dptr_r, dptr_nxt_s;
  logic [IDX_W-1:0]     iptr_r, iptr_nxt_s;
  logic [IDX_W-1:0]     pick_s;

  logic [NUM_CORES-1:0] owner_mask_s, supplier_mask_s;
  logic [NUM_CORES-1:0] dreq_s, dirty_s;
  logic                 all_trans_s;

  logic [NUM_CORES-1:0] iwait_s, dwait_s, ccwait_s, ccinv_s;
  logic [WORD_W-1:0]    iload_s, dload_s, snoopaddr_s, ramaddr_s, ramstore_s;
  logic                 ram_ren_s, ram_wen_s;

  // First requester at or after ptr, wrapping modulo NUM_CORES.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!found && req[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Lowest set index; the scan runs downward so the last hit wins.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CORES-1:0] v);
    logic [IDX_W-1:0] pick;
    pick = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (v[i]) pick = IDX_W'(i);
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] k);
    return (int'(k) == NUM_CORES - 1) ? '0 : k + IDX_W'(1);
  endfunction

  function automatic logic [WORD_W-1:0] word_of(input logic [NUM_CORES*WORD_W-1:0] v,
                                                input logic [IDX_W-1:0] k);
    return v[int'(k)*WORD_W +: WORD_W];
  endfunction

  // One-hot masks of the current owner and supplier, plus snoop summaries.
  always_comb begin
    owner_mask_s              = '0;
    owner_mask_s[owner_r]     = 1'b1;
    supplier_mask_s           = '0;
    supplier_mask_s[supplier_r] = 1'b1;
    dreq_s      = bus.dREN | bus.dWEN;
    // The owner is never snooped, so it counts as already answered.
    all_trans_s = &(bus.cctrans | owner_mask_s);
    dirty_s     = bus.ccdirty & ~owner_mask_s;
  end

  // Next-state, grant and round-robin pointer logic.
  always_comb begin
    state_nxt_s    = state_r;
    owner_nxt_s    = owner_r;
    supplier_nxt_s = supplier_r;
    dptr_nxt_s     = dptr_r;
    iptr_nxt_s     = iptr_r;
    pick_s         = '0;
    case (state_r)
      IDLE: begin
        if (|dreq_s) begin
          pick_s      = rr_pick(dreq_s, dptr_r);
          owner_nxt_s = pick_s;
          dptr_nxt_s  = next_ptr(pick_s);
          // A writeback frees a dirty line, so it beats a read from the same core.
          state_nxt_s = bus.dWEN[pick_s] ? WB1 : SNOOP;
        end else if (|bus.iREN) begin
          pick_s      = rr_pick(bus.iREN, iptr_r);
          owner_nxt_s = pick_s;
          iptr_nxt_s  = next_ptr(pick_s);
          state_nxt_s = IFETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      IFETCH: state_nxt_s = bus.ram_ready ? IDLE : IFETCH;
      WB1:    state_nxt_s = bus.ram_ready ? WB2  : WB1;
      WB2:    state_nxt_s = bus.ram_ready ? IDLE : WB2;
      SNOOP: begin
        if (all_trans_s) begin
          if (|dirty_s) begin
            supplier_nxt_s = lowest_set(dirty_s);
            state_nxt_s    = C2C1;
          end else begin
            state_nxt_s    = MLD1;
          end
        end else begin
          state_nxt_s = SNOOP;
        end
      end
      C2C1:   state_nxt_s = bus.ram_ready ? C2C2 : C2C1;
      C2C2:   state_nxt_s = bus.ram_ready ? IDLE : C2C2;
      MLD1:   state_nxt_s = bus.ram_ready ? MLD2 : MLD1;
      MLD2:   state_nxt_s = bus.ram_ready ? IDLE : MLD2;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, owner, supplier and pointer registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r    <= IDLE;
      owner_r    <= '0;
      supplier_r <= '0;
      dptr_r     <= '0;
      iptr_r     <= '0;
    end else begin
      state_r    <= state_nxt_s;
      owner_r    <= owner_nxt_s;
      supplier_r <= supplier_nxt_s;
      dptr_r     <= dptr_nxt_s;
      iptr_r     <= iptr_nxt_s;
    end
  end

  // Bus outputs as a function of state, registered owner/supplier and inputs.
  always_comb begin
    iwait_s     = '1;
    dwait_s     = '1;
    iload_s     = '0;
    dload_s     = '0;
    ccwait_s    = '0;
    ccinv_s     = '0;
    snoopaddr_s = '0;
    ram_ren_s   = 1'b0;
    ram_wen_s   = 1'b0;
    ramaddr_s   = '0;
    ramstore_s  = '0;
    case (state_r)
      IFETCH: begin
        ram_ren_s = 1'b1;
        ramaddr_s = word_of(bus.iaddr, owner_r);
        iload_s   = bus.ramload;
        iwait_s   = bus.ram_ready ? ~owner_mask_s : '1;
      end
      WB1, WB2: begin
        ram_wen_s  = 1'b1;
        ramaddr_s  = word_of(bus.daddr, owner_r);
        ramstore_s = word_of(bus.dstore, owner_r);
        dwait_s    = bus.ram_ready ? ~owner_mask_s : '1;
      end
      SNOOP: begin
        ccwait_s    = ~owner_mask_s;
        ccinv_s     = bus.ccwrite[owner_r] ? ~owner_mask_s : '0;
        snoopaddr_s = word_of(bus.daddr, owner_r);
      end
      C2C1, C2C2: begin
        // Supplier's word goes to the requester and to RAM in the same cycle.
        ccwait_s   = supplier_mask_s;
        dload_s    = word_of(bus.dstore, supplier_r);
        ram_wen_s  = 1'b1;
        ramaddr_s  = word_of(bus.daddr, supplier_r);
        ramstore_s = word_of(bus.dstore, supplier_r);
        dwait_s    = bus.ram_ready ? ~(owner_mask_s | supplier_mask_s) : '1;
      end
      MLD1, MLD2: begin
        ram_ren_s = 1'b1;
        ramaddr_s = word_of(bus.daddr, owner_r);
        dload_s   = bus.ramload;
        dwait_s   = bus.ram_ready ? ~owner_mask_s : '1;
      end
      default: begin
        iwait_s = '1;
      end
    endcase
  end

  assign bus.iwait       = iwait_s;
  assign bus.dwait       = dwait_s;
  assign bus.iload       = iload_s;
  assign bus.dload       = dload_s;
  assign bus.ccwait      = ccwait_s;
  assign bus.ccinv       = ccinv_s;
  assign bus.ccsnoopaddr = snoopaddr_s;
  assign bus.ramREN      = ram_ren_s;
  assign bus.ramWEN      = ram_wen_s;
  assign bus.ramaddr     = ramaddr_s;
  assign bus.ramstore    = ramstore_s;

`ifdef COHERENCE_PERF_EN
  // Event counters: snoop completions, cache-to-cache blocks, invalidating snoops.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      snoop_cnt <= 32'd0;
      c2c_cnt   <= 32'd0;
      inv_cnt   <= 32'd0;
    end else begin
      if (state_r == SNOOP && all_trans_s) begin
        snoop_cnt <= snoop_cnt + 32'd1;
        if (|ccinv_s) inv_cnt <= inv_cnt + 32'd1;
        else          inv_cnt <= inv_cnt;
      end else begin
        snoop_cnt <= snoop_cnt;
        inv_cnt   <= inv_cnt;
      end
      if (state_r == C2C2 && bus.ram_ready) c2c_cnt <= c2c_cnt + 32'd1;
      else                                  c2c_cnt <= c2c_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_coherence_bus_ctrl
// Directed bench for coherence_bus_ctrl with NUM_CORES=4, WORD_W=32.
// Inputs change on the falling clock edge; outputs are compared 2 time units
// later, well clear of the rising edge that advances the controller.
// ---------------------------------------------------------------------------
module tb_coherence_bus_ctrl;

  localparam int NC = 4;
  localparam int WW = 32;

  typedef struct {
    string        nm;
    logic [3:0]   iren, dren, dwen, ccw, cct, ccd;
    logic         rr;
    logic [31:0]  rl;
    logic [127:0] da, ds;
    logic [3:0]   e_iw, e_dw, e_ccw, e_cci;
    logic         e_ren, e_wen;
    logic [31:0]  e_addr, e_store, e_dload, e_iload, e_snoop;
  } vec_t;

  logic CLK;
  logic nRST;
  int   errors;
  int   checks;
  vec_t vecs[$];

  coherence_bus_ctrl_if #(.NUM_CORES(NC), .WORD_W(WW)) bus ();

  coherence_bus_ctrl #(.NUM_CORES(NC), .WORD_W(WW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [127:0] pk(input logic [31:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input string nm,
      input logic [3:0] iren, dren, dwen, ccw, cct, ccd,
      input logic rr, input logic [31:0] rl, input logic [127:0] da, ds,
      input logic [3:0] e_iw, e_dw, e_ccw, e_cci,
      input logic e_ren, e_wen,
      input logic [31:0] e_addr, e_store, e_dload, e_iload, e_snoop);
    vec_t v;
    v.nm = nm; v.iren = iren; v.dren = dren; v.dwen = dwen;
    v.ccw = ccw; v.cct = cct; v.ccd = ccd; v.rr = rr; v.rl = rl;
    v.da = da; v.ds = ds;
    v.e_iw = e_iw; v.e_dw = e_dw; v.e_ccw = e_ccw; v.e_cci = e_cci;
    v.e_ren = e_ren; v.e_wen = e_wen; v.e_addr = e_addr; v.e_store = e_store;
    v.e_dload = e_dload; v.e_iload = e_iload; v.e_snoop = e_snoop;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_row(input vec_t v);
    chk({v.nm, ".iwait"},    32'(bus.iwait),       32'(v.e_iw));
    chk({v.nm, ".dwait"},    32'(bus.dwait),       32'(v.e_dw));
    chk({v.nm, ".ccwait"},   32'(bus.ccwait),      32'(v.e_ccw));
    chk({v.nm, ".ccinv"},    32'(bus.ccinv),       32'(v.e_cci));
    chk({v.nm, ".ramREN"},   32'(bus.ramREN),      32'(v.e_ren));
    chk({v.nm, ".ramWEN"},   32'(bus.ramWEN),      32'(v.e_wen));
    chk({v.nm, ".ramaddr"},  bus.ramaddr,          v.e_addr);
    chk({v.nm, ".ramstore"}, bus.ramstore,         v.e_store);
    chk({v.nm, ".dload"},    bus.dload,            v.e_dload);
    chk({v.nm, ".iload"},    bus.iload,            v.e_iload);
    chk({v.nm, ".snoop"},    bus.ccsnoopaddr,      v.e_snoop);
  endtask

  task automatic clear_inputs();
    bus.iREN = 4'h0; bus.dREN = 4'h0; bus.dWEN = 4'h0;
    bus.ccwrite = 4'h0; bus.cctrans = 4'h0; bus.ccdirty = 4'h0;
    bus.daddr = 128'h0; bus.dstore = 128'h0;
    bus.ramload = 32'h0; bus.ram_ready = 1'b1;
  endtask

  initial begin
    logic [127:0] z;
    z = 128'h0;
    errors = 0;
    checks = 0;

    // Fetch round-robin: grants 0,1,2,3,0 with one IDLE cycle between each.
    vecs.push_back(mk("f_idle0", 4'hF,4'h0,4'h0,4'h0,4'h0,4'h0, 1'b1, 32'h5A00, z,z, 4'hF,4'hF,4'h0,4'h0, 1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'h0));
    vecs.push_back(mk("f_c0",    4'hF,4'h0,4'h0,4'h0,4'h0,4'h0, 1'b1, 32'h5A01, z,z, 4'hE,4'hF,4'h0,4'h0, 1'b1,1'b0, 32'h1000,32'h0,32'h0,32'h5A01,32'h0));
    vecs.push_back(mk("f_idle1", 4'hF,4'h0,4'h0,4'h0,4'h0,4'h0, 1'b1, 32'h5A02, z,z, 4'hF,4'hF,4'h0,4'h0, 1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'h0));
    vecs.push_back(mk("f_c1",    4'hF,4'h0,4'h0,4'h0,4'h0,4'h0, 1'b1, 32'h5A03, z,z, 4'hD,4'hF,4'h0,4'h0, 1'b1,1'b0, 32'h1004,32'h0,32'h0,32'h5A03,32'h0));
    vecs.push_back(mk("f_idle2", 4'hF,4'h0,4'h0,4'h0,4'h0,4'h0, 1'b1, 32'h5A04, z,z, 4'hF,4'hF,4'h0,4'h0, 1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'h0));
    vecs.push_back(mk("f_c2",    4'hF,4'h0,4'h0,4'h0,4'h0,4'h0, 1'b1, 32'h5A05, z,z, 4'hB,4'hF,4'h0,4'h0, 1'b1,1'b0, 32'h1008,32'h0,32'h0,32'h5A05,32'h0));
    vecs.push_back(mk("f_idle3", 4'hF,4'h0,4'h0,4'h0,4'h0,4'h0, 1'b1, 32'h5A06, z,z, 4'hF,4'hF,4'h0,4'h0, 1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'h0));
    vecs.push_back(mk("f_c3",    4'hF,4'h0,4'h0,4'h0,4'h0,4'h0, 1'b1, 32'h5A07, z,z, 4'h7,4'hF,4'h0,4'h0, 1'b1,1'b0, 32'h100C,32'h0,32'h0,32'h5A07,32'h0));
    vecs.push_back(mk("f_idle4", 4'hF,4'h0,4'h0,4'h0,4'h0,4'h0, 1'b1, 32'h5A08, z,z, 4'hF,4'hF,4'h0,4'h0, 1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'h0));
    vecs.push_back(mk("f_c0_wrap",4'hF,4'h0,4'h0,4'h0,4'h0,4'h0, 1'b1, 32'h5A09, z,z, 4'hE,4'hF,4'h0,4'h0, 1'b1,1'b0, 32'h1000,32'h0,32'h0,32'h5A09,32'h0));
    // Core 2 writeback (with one RAM stall) while core 0 fetch waits.
    vecs.push_back(mk("wb_idle", 4'h1,4'h0,4'h4,4'h0,4'h0,4'h0, 1'b1, 32'h0, pk(0,32'h100,0,0), pk(0,32'hAAAA,0,0), 4'hF,4'hF,4'h0,4'h0, 1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'h0));
    vecs.push_back(mk("wb1_stall",4'h1,4'h0,4'h4,4'h0,4'h0,4'h0, 1'b0, 32'h0, pk(0,32'h100,0,0), pk(0,32'hAAAA,0,0), 4'hF,4'hF,4'h0,4'h0, 1'b0,1'b1, 32'h100,32'hAAAA,32'h0,32'h0,32'h0));
    vecs.push_back(mk("wb1",     4'h1,4'h0,4'h4,4'h0,4'h0,4'h0, 1'b1, 32'h0, pk(0,32'h100,0,0), pk(0,32'hAAAA,0,0), 4'hF,4'hB,4'h0,4'h0, 1'b0,1'b1, 32'h100,32'hAAAA,32'h0,32'h0,32'h0));
    vecs.push_back(mk("wb2",     4'h1,4'h0,4'h4,4'h0,4'h0,4'h0, 1'b1, 32'h0, pk(0,32'h104,0,0), pk(0,32'hBBBB,0,0), 4'hF,4'hB,4'h0,4'h0, 1'b0,1'b1, 32'h104,32'hBBBB,32'h0,32'h0,32'h0));
    vecs.push_back(mk("wb_done", 4'h1,4'h0,4'h0,4'h0,4'h0,4'h0, 1'b1, 32'h7777, z,z, 4'hF,4'hF,4'h0,4'h0, 1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'h0));
    vecs.push_back(mk("f_after_wb",4'h1,4'h0,4'h0,4'h0,4'h0,4'h0, 1'b1, 32'h7777, z,z, 4'hE,4'hF,4'h0,4'h0, 1'b1,1'b0, 32'h1000,32'h0,32'h0,32'h7777,32'h0));
    vecs.push_back(mk("f_done",  4'h0,4'h0,4'h0,4'h0,4'h0,4'h0, 1'b1, 32'h0, z,z, 4'hF,4'hF,4'h0,4'h0, 1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'h0));
    // Core 0 shared read, clean snoop, block from RAM.
    vecs.push_back(mk("rd_idle", 4'h0,4'h1,4'h0,4'h0,4'hF,4'h0, 1'b1, 32'h0, pk(0,0,0,32'h200), z, 4'hF,4'hF,4'h0,4'h0, 1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'h0));
    vecs.push_back(mk("rd_snoop",4'h0,4'h1,4'h0,4'h0,4'hF,4'h0, 1'b1, 32'h0, pk(0,0,0,32'h200), z, 4'hF,4'hF,4'hE,4'h0, 1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'h200));
    vecs.push_back(mk("rd_mld1", 4'h0,4'h1,4'h0,4'h0,4'hF,4'h0, 1'b1, 32'h11, pk(0,0,0,32'h200), z, 4'hF,4'hE,4'h0,4'h0, 1'b1,1'b0, 32'h200,32'h0,32'h11,32'h0,32'h0));
    vecs.push_back(mk("rd_mld2", 4'h0,4'h1,4'h0,4'h0,4'hF,4'h0, 1'b1, 32'h22, pk(0,0,0,32'h204), z, 4'hF,4'hE,4'h0,4'h0, 1'b1,1'b0, 32'h204,32'h0,32'h22,32'h0,32'h0));
    vecs.push_back(mk("rd_done", 4'h0,4'h0,4'h0,4'h0,4'h0,4'h0, 1'b1, 32'h0, z,z, 4'hF,4'hF,4'h0,4'h0, 1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'h0));
    // Core 1 read-exclusive; core 3 holds the block dirty and forwards it.
    vecs.push_back(mk("rx_idle", 4'h0,4'h2,4'h0,4'h2,4'hF,4'h8, 1'b1, 32'h0, pk(32'h300,0,32'h300,0), pk(32'hDEAD,0,0,0), 4'hF,4'hF,4'h0,4'h0, 1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'h0));
    vecs.push_back(mk("rx_snoop",4'h0,4'h2,4'h0,4'h2,4'hF,4'h8, 1'b1, 32'h0, pk(32'h300,0,32'h300,0), pk(32'hDEAD,0,0,0), 4'hF,4'hF,4'hD,4'hD, 1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'h300));
    vecs.push_back(mk("rx_c2c1", 4'h0,4'h2,4'h0,4'h2,4'hF,4'h8, 1'b1, 32'h0, pk(32'h300,0,32'h300,0), pk(32'hDEAD,0,0,0), 4'hF,4'h5,4'h8,4'h0, 1'b0,1'b1, 32'h300,32'hDEAD,32'hDEAD,32'h0,32'h0));
    vecs.push_back(mk("rx_c2c2", 4'h0,4'h2,4'h0,4'h2,4'hF,4'h8, 1'b1, 32'h0, pk(32'h304,0,32'h304,0), pk(32'hBEEF,0,0,0), 4'hF,4'h5,4'h8,4'h0, 1'b0,1'b1, 32'h304,32'hBEEF,32'hBEEF,32'h0,32'h0));
    vecs.push_back(mk("rx_done", 4'h0,4'h0,4'h0,4'h0,4'h0,4'h0, 1'b1, 32'h0, z,z, 4'hF,4'hF,4'h0,4'h0, 1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'h0));

    // Reset state.
    nRST = 1'b0;
    bus.iaddr = pk(32'h100C, 32'h1008, 32'h1004, 32'h1000);
    clear_inputs();
    #2;
    chk("rst.iwait",  32'(bus.iwait),  32'hF);
    chk("rst.dwait",  32'(bus.dwait),  32'hF);
    chk("rst.ccwait", 32'(bus.ccwait), 32'h0);
    chk("rst.ccinv",  32'(bus.ccinv),  32'h0);
    chk("rst.ramREN", 32'(bus.ramREN), 32'h0);
    chk("rst.ramWEN", 32'(bus.ramWEN), 32'h0);
    chk("rst.ramaddr", bus.ramaddr,    32'h0);
    chk("rst.dload",   bus.dload,      32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    // Table-driven section.
    foreach (vecs[i]) begin
      bus.iREN = vecs[i].iren; bus.dREN = vecs[i].dren; bus.dWEN = vecs[i].dwen;
      bus.ccwrite = vecs[i].ccw; bus.cctrans = vecs[i].cct; bus.ccdirty = vecs[i].ccd;
      bus.ram_ready = vecs[i].rr; bus.ramload = vecs[i].rl;
      bus.daddr = vecs[i].da; bus.dstore = vecs[i].ds;
      #2;
      check_row(vecs[i]);
      @(negedge CLK);
    end

    // Core 0 read: core 3 answers 5 cycles late; cores 1 and 3 both claim
    // dirty, so core 1 (lowest index) supplies.
    clear_inputs();
    bus.dREN = 4'h1; bus.cctrans = 4'h6; bus.ccdirty = 4'hA;
    bus.daddr = pk(0, 0, 32'h400, 32'h400); bus.dstore = pk(32'h99, 0, 32'h77, 0);
    #2;
    chk("late.idle_ren", 32'(bus.ramREN), 32'h0);
    @(negedge CLK);
    for (int c = 0; c < 5; c++) begin
      #2;
      chk($sformatf("late.snoop%0d_ccwait", c), 32'(bus.ccwait), 32'hE);
      chk($sformatf("late.snoop%0d_ren", c),    32'(bus.ramREN), 32'h0);
      chk($sformatf("late.snoop%0d_wen", c),    32'(bus.ramWEN), 32'h0);
      @(negedge CLK);
    end
    bus.cctrans = 4'hE;
    #2;
    chk("late.snoop_exit_ccwait", 32'(bus.ccwait), 32'hE);
    @(negedge CLK);
    #2;
    chk("late.c2c1_ccwait", 32'(bus.ccwait), 32'h2);
    chk("late.c2c1_wen",    32'(bus.ramWEN), 32'h1);
    chk("late.c2c1_addr",   bus.ramaddr,     32'h400);
    chk("late.c2c1_store",  bus.ramstore,    32'h77);
    chk("late.c2c1_dload",  bus.dload,       32'h77);
    chk("late.c2c1_dwait",  32'(bus.dwait),  32'hC);
    @(negedge CLK);
    bus.daddr = pk(0, 0, 32'h404, 32'h404); bus.dstore = pk(32'h99, 0, 32'h88, 0);
    #2;
    chk("late.c2c2_store",  bus.ramstore,    32'h88);
    chk("late.c2c2_dwait",  32'(bus.dwait),  32'hC);
    @(negedge CLK);
    clear_inputs();
    #2;
    chk("late.done_wen",    32'(bus.ramWEN), 32'h0);
    @(negedge CLK);

    // Core 2 read, reset asserted while MLD1 is stalled on RAM.
    bus.dREN = 4'h4; bus.cctrans = 4'hF; bus.ram_ready = 1'b0;
    bus.daddr = pk(0, 32'h500, 0, 32'h600);
    #2;
    chk("rstmid.idle_ren", 32'(bus.ramREN), 32'h0);
    @(negedge CLK);
    #2;
    chk("rstmid.snoop_ccwait", 32'(bus.ccwait), 32'hB);
    @(negedge CLK);
    #2;
    chk("rstmid.mld1_ren",  32'(bus.ramREN), 32'h1);
    chk("rstmid.mld1_addr", bus.ramaddr,     32'h500);
    nRST = 1'b0;
    #1;
    chk("rstmid.dwait",   32'(bus.dwait),  32'hF);
    chk("rstmid.ramREN",  32'(bus.ramREN), 32'h0);
    chk("rstmid.ramaddr", bus.ramaddr,     32'h0);
    chk("rstmid.ccwait",  32'(bus.ccwait), 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    bus.dREN = 4'h9; bus.ram_ready = 1'b1; bus.ramload = 32'h66;
    #2;
    chk("post.idle_ren", 32'(bus.ramREN), 32'h0);
    @(negedge CLK);
    #2;
    chk("post.snoop_ccwait", 32'(bus.ccwait),   32'hE);
    chk("post.snoop_addr",   bus.ccsnoopaddr,   32'h600);
    @(negedge CLK);
    #2;
    chk("post.mld1_ren",   32'(bus.ramREN), 32'h1);
    chk("post.mld1_addr",  bus.ramaddr,     32'h600);
    chk("post.mld1_dload", bus.dload,       32'h66);
    chk("post.mld1_dwait", 32'(bus.dwait),  32'hE);
    @(negedge CLK);
    bus.daddr = pk(0, 32'h500, 0, 32'h604);
    #2;
    chk("post.mld2_addr",  bus.ramaddr,     32'h604);
    chk("post.mld2_dwait", 32'(bus.dwait),  32'hE);
    @(negedge CLK);
    clear_inputs();
    #2;
    chk("post.done_ren",   32'(bus.ramREN), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
